fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage. It consumes the branch-resolution unit's flush pulse and redirect target, and owns the architectural PC register. It issues instruction-memory requests and tolerates multi-cycle memory latency. It fills the IF/ID pipeline register, honouring hazard stalls, squashing wrong-path instructions on flush, and stopping fetch on HALT.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
HALT_OPCODE, 4'hF, value of instr[15:12] that marks HALT.
NOP_INSTR, 16'h0000, encoding placed in IF/ID when the slot is a bubble.

Ports:
clk  in  1  single system clock; all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
stall  in  1  hazard unit: hold PC and IF/ID this cycle.
flush  in  1  branch resolution: taken/redirect, squash the younger instruction.
br_target  in  16  redirect PC; valid only when flush=1.
imem_req  out  1  fetch request, level-sensitive.
imem_addr  out  16  fetch address; equals pc.
imem_rdy  in  1  imem_data valid for imem_addr this cycle.
imem_data  in  16  fetched instruction.
ifid_instr  out  16  IF/ID instruction.
ifid_pc_plus2  out  16  IF/ID fall-through address (fetch PC + 2).
ifid_valid  out  1  IF/ID holds a real instruction.
pc  out  16  current fetch PC.
halted  out  1  fetch stopped on HALT.

Behaviour:
- Reset: pc=RESET_PC, state=FETCH, ifid_instr=NOP_INSTR, ifid_pc_plus2=0, ifid_valid=0, halted=0, saved target=0. imem_req=0 while rst=1.
- States: FETCH, DRAIN, HALTED. halted = (state==HALTED). imem_req = (state!=HALTED) & ~rst. imem_addr=pc at all times.
- imem protocol: imem_addr must stay stable while imem_req=1 and imem_rdy=0. A rdy=1 cycle is a completed fetch. Same-cycle rdy is allowed, giving one instruction per cycle.
- Priority each cycle: rst > flush > stall > normal.
- FETCH, normal (no flush, no stall):
  - rdy=1, non-HALT instruction: ifid_instr<=imem_data, ifid_pc_plus2<=pc+2, ifid_valid<=1, pc<=pc+2.
  - rdy=1, instr[15:12]==HALT_OPCODE: IF/ID loaded as above with valid=1, pc unchanged, state<=HALTED.
  - rdy=0: ifid_valid<=0, ifid_instr<=NOP_INSTR (bubble), pc held.
- FETCH, stall=1 (no flush): pc and all IF/ID fields hold. Returned data is ignored and re-requested next cycle at the same address.
- FETCH, flush=1: ifid_valid<=0, ifid_instr<=NOP_INSTR. Returned data is discarded regardless of opcode.
  - rdy=1: pc<=br_target, stay FETCH.
  - rdy=0: saved target<=br_target, state<=DRAIN, pc held, because the address must remain stable.
- DRAIN: IF/ID stays a bubble. Stall is ignored.
  - flush=1: saved target is overwritten with the newer br_target.
  - rdy=1: data discarded, pc<=saved target (or br_target if flush=1 this same cycle), state<=FETCH.
- HALTED: no requests, pc and IF/ID held, stall ignored.
  - flush=1: the HALT was wrong-path. pc<=br_target, ifid_valid<=0, state<=FETCH, halted deasserts next cycle.
- Arithmetic: PC increment is 16-bit modulo, so 16'hFFFE+2 = 16'h0000. No carry/overflow is reported. br_target is used verbatim.
- Reset mid-DRAIN: the pending fetch is abandoned. imem shares rst and also drops its request.
- Latency: the instruction enters IF/ID on the edge following the imem_rdy cycle. A flush takes effect on the next edge.

Decomposition:
- Shared cpu package holds: RESET_PC, HALT_OPCODE, NOP_INSTR defaults, the 16-bit word width constant, and the fetch state enum (FETCH, DRAIN, HALTED).
- One sub-module: the PC+2 incrementer uses the existing add block with B=16'h0002, sub=0; its overflow output is left unused.
- The state machine and the IF/ID register stay inline.

Test Plan:
- Reset, imem_rdy held 1, memory returns 16'h1234, 16'h5678, … → pc 0,2,4; IF/ID valid each cycle with pc_plus2 2,4,6.
- stall=1 for 2 cycles while rdy=1 at pc=4 → pc stays 4, IF/ID unchanged; fetch at 4 is accepted on the first unstalled cycle.
- flush=1, br_target=16'h0040, rdy=1 → next pc=16'h0040, ifid_valid=0, ifid_instr=NOP_INSTR; flush+stall same cycle gives an identical result.
- flush=1, br_target=16'h0080 with rdy=0 for 3 cycles → imem_addr stays at old pc until rdy; data is dropped, then pc=16'h0080, IF/ID never valid meanwhile. A second flush to 16'h00C0 during DRAIN → pc=16'h00C0.
- Fetch 16'hF000 at pc=16'h0010 → ifid_valid=1, halted=1, imem_req=0, pc stays 16'h0010. A later flush to 16'h0020 → fetch resumes at 16'h0020.
- pc=16'hFFFE, rdy=1 → pc wraps to 16'h0000, ifid_pc_plus2=16'h0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions for the fetch stage: word width, reset/halt/NOP defaults
// and the fetch FSM state encoding.
package fetch_stage_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [WORD_W-1:0] DEF_RESET_PC    = 16'h0000;
    localparam logic [3:0]        DEF_HALT_OPCODE = 4'hF;
    localparam logic [WORD_W-1:0] DEF_NOP_INSTR   = 16'h0000;

    typedef enum logic [1:0] {
        StFetch,
        StDrain,
        StHalted
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_add.sv
// Generic W-bit adder/subtractor with signed-overflow flag.
module fetch_stage_add #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);

    logic [W-1:0] w_b_eff;

    always_comb begin
        w_b_eff = i_sub ? ~i_b : i_b;
        o_sum   = i_a + w_b_eff + {{(W-1){1'b0}}, i_sub};
        o_ovf   = (i_a[W-1] == w_b_eff[W-1]) && (o_sum[W-1] != i_a[W-1]);
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem requests, fills IF/ID and
// handles stall, flush/redirect (including mid-fetch redirects) and HALT.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC    = DEF_RESET_PC,
    parameter logic [3:0]        HALT_OPCODE = DEF_HALT_OPCODE,
    parameter logic [WORD_W-1:0] NOP_INSTR   = DEF_NOP_INSTR
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_stall,
    input  logic              i_flush,
    input  logic [WORD_W-1:0] i_br_target,
    output logic              o_imem_req,
    output logic [WORD_W-1:0] o_imem_addr,
    input  logic              i_imem_rdy,
    input  logic [WORD_W-1:0] i_imem_data,
    output logic [WORD_W-1:0] o_ifid_instr,
    output logic [WORD_W-1:0] o_ifid_pc_plus2,
    output logic              o_ifid_valid,
    output logic [WORD_W-1:0] o_pc,
    output logic              o_halted
);

    fetch_state_e      r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_saved_target;
    logic [WORD_W-1:0] r_ifid_instr;
    logic [WORD_W-1:0] r_ifid_pc_plus2;
    logic              r_ifid_valid;

    logic [WORD_W-1:0] w_pc_plus2;
    logic              w_unused_ovf;
    logic              w_is_halt;

    fetch_stage_add #(
        .W (WORD_W)
    ) u_pc_inc (
        .i_a   (r_pc),
        .i_b   (16'h0002),
        .i_sub (1'b0),
        .o_sum (w_pc_plus2),
        .o_ovf (w_unused_ovf)
    );

    assign w_is_halt = (i_imem_data[15:12] == HALT_OPCODE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state         <= StFetch;
            r_pc            <= RESET_PC;
            r_saved_target  <= '0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_pc_plus2 <= '0;
            r_ifid_valid    <= 1'b0;
        end else begin
            unique case (r_state)
                StFetch: begin
                    if (i_flush) begin
                        r_ifid_valid <= 1'b0;
                        r_ifid_instr <= NOP_INSTR;
                        if (i_imem_rdy) begin
                            r_pc <= i_br_target;
                        end else begin
                            // Outstanding fetch must complete at the old address first.
                            r_saved_target <= i_br_target;
                            r_state        <= StDrain;
                        end
                    end else if (!i_stall) begin
                        if (i_imem_rdy) begin
                            r_ifid_instr    <= i_imem_data;
                            r_ifid_pc_plus2 <= w_pc_plus2;
                            r_ifid_valid    <= 1'b1;
                            if (w_is_halt) begin
                                r_state <= StHalted;
                            end else begin
                                r_pc <= w_pc_plus2;
                            end
                        end else begin
                            r_ifid_valid <= 1'b0;
                            r_ifid_instr <= NOP_INSTR;
                        end
                    end
                end
                StDrain: begin
                    r_ifid_valid <= 1'b0;
                    r_ifid_instr <= NOP_INSTR;
                    if (i_flush) begin
                        r_saved_target <= i_br_target;
                    end
                    if (i_imem_rdy) begin
                        r_pc    <= i_flush ? i_br_target : r_saved_target;
                        r_state <= StFetch;
                    end
                end
                StHalted: begin
                    if (i_flush) begin
                        r_pc         <= i_br_target;
                        r_ifid_valid <= 1'b0;
                        r_state      <= StFetch;
                    end
                end
                default: r_state <= StFetch;
            endcase
        end
    end

    assign o_imem_req      = (r_state != StHalted) && !i_rst;
    assign o_imem_addr     = r_pc;
    assign o_pc            = r_pc;
    assign o_halted        = (r_state == StHalted);
    assign o_ifid_instr    = r_ifid_instr;
    assign o_ifid_pc_plus2 = r_ifid_pc_plus2;
    assign o_ifid_valid    = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage plus a reset-during-drain sequence.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [15:0] br_target;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic [15:0] pc;
    logic        halted;

    int n_vec;
    int n_err;

    fetch_stage u_dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_stall         (stall),
        .i_flush         (flush),
        .i_br_target     (br_target),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_rdy      (imem_rdy),
        .i_imem_data     (imem_data),
        .o_ifid_instr    (ifid_instr),
        .o_ifid_pc_plus2 (ifid_pc_plus2),
        .o_ifid_valid    (ifid_valid),
        .o_pc            (pc),
        .o_halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [15:0] tgt;
        logic        rdy;
        logic [15:0] data;
        logic [15:0] e_pc;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pp2;
        logic        e_halted;
        logic        e_req;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic e_valid,
                           input logic [15:0] e_instr, input logic [15:0] e_pp2,
                           input logic e_halted, input logic e_req);
        chk({tag, " pc"}, pc, e_pc);
        chk({tag, " imem_addr"}, imem_addr, e_pc);
        chk({tag, " ifid_valid"}, {15'd0, ifid_valid}, {15'd0, e_valid});
        chk({tag, " ifid_instr"}, ifid_instr, e_instr);
        chk({tag, " ifid_pc_plus2"}, ifid_pc_plus2, e_pp2);
        chk({tag, " halted"}, {15'd0, halted}, {15'd0, e_halted});
        chk({tag, " imem_req"}, {15'd0, imem_req}, {15'd0, e_req});
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic [15:0] t,
                                input logic r, input logic [15:0] d, input logic [15:0] epc,
                                input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                                input logic eh, input logic eq);
        vec_t v;
        v.stall = s; v.flush = f; v.tgt = t; v.rdy = r; v.data = d;
        v.e_pc = epc; v.e_valid = ev; v.e_instr = ei; v.e_pp2 = ep;
        v.e_halted = eh; v.e_req = eq;
        return v;
    endfunction

    task automatic step(input logic s, input logic f, input logic [15:0] t,
                        input logic r, input logic [15:0] d);
        stall = s; flush = f; br_target = t; imem_rdy = r; imem_data = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        //             stall flush tgt     rdy data     | pc      v  instr    pp2      h  req
        tbl[0]  = mk(0, 0, 16'h0000, 1, 16'h1234, 16'h0002, 1, 16'h1234, 16'h0002, 0, 1);
        tbl[1]  = mk(0, 0, 16'h0000, 1, 16'h5678, 16'h0004, 1, 16'h5678, 16'h0004, 0, 1);
        tbl[2]  = mk(1, 0, 16'h0000, 1, 16'h9ABC, 16'h0004, 1, 16'h5678, 16'h0004, 0, 1);
        tbl[3]  = mk(1, 0, 16'h0000, 1, 16'h9ABC, 16'h0004, 1, 16'h5678, 16'h0004, 0, 1);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 16'h9ABC, 16'h0006, 1, 16'h9ABC, 16'h0006, 0, 1);
        tbl[5]  = mk(0, 1, 16'h0040, 1, 16'h1111, 16'h0040, 0, 16'h0000, 16'h0006, 0, 1);
        tbl[6]  = mk(0, 0, 16'h0000, 1, 16'h2222, 16'h0042, 1, 16'h2222, 16'h0042, 0, 1);
        tbl[7]  = mk(1, 1, 16'h0040, 1, 16'h3333, 16'h0040, 0, 16'h0000, 16'h0042, 0, 1);
        tbl[8]  = mk(0, 0, 16'h0000, 1, 16'h4444, 16'h0042, 1, 16'h4444, 16'h0042, 0, 1);
        // redirect while the fetch at 0x0042 is outstanding
        tbl[9]  = mk(0, 1, 16'h0080, 0, 16'h0000, 16'h0042, 0, 16'h0000, 16'h0042, 0, 1);
        tbl[10] = mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0042, 0, 16'h0000, 16'h0042, 0, 1);
        tbl[11] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0042, 0, 16'h0000, 16'h0042, 0, 1);
        tbl[12] = mk(0, 0, 16'h0000, 1, 16'hF000, 16'h0080, 0, 16'h0000, 16'h0042, 0, 1);
        tbl[13] = mk(0, 0, 16'h0000, 1, 16'h5555, 16'h0082, 1, 16'h5555, 16'h0082, 0, 1);
        tbl[14] = mk(0, 1, 16'h00A0, 0, 16'h0000, 16'h0082, 0, 16'h0000, 16'h0082, 0, 1);
        tbl[15] = mk(0, 1, 16'h00C0, 0, 16'h0000, 16'h0082, 0, 16'h0000, 16'h0082, 0, 1);
        tbl[16] = mk(0, 0, 16'h0000, 1, 16'h6666, 16'h00C0, 0, 16'h0000, 16'h0082, 0, 1);
        tbl[17] = mk(0, 0, 16'h0000, 0, 16'h0000, 16'h00C0, 0, 16'h0000, 16'h0082, 0, 1);
        tbl[18] = mk(0, 1, 16'h00E0, 0, 16'h0000, 16'h00C0, 0, 16'h0000, 16'h0082, 0, 1);
        tbl[19] = mk(0, 1, 16'h0010, 1, 16'h7777, 16'h0010, 0, 16'h0000, 16'h0082, 0, 1);
        // HALT at 0x0010, then wrong-path recovery
        tbl[20] = mk(0, 0, 16'h0000, 1, 16'hF000, 16'h0010, 1, 16'hF000, 16'h0012, 1, 0);
        tbl[21] = mk(1, 0, 16'h0000, 1, 16'h1234, 16'h0010, 1, 16'hF000, 16'h0012, 1, 0);
        tbl[22] = mk(0, 1, 16'h0020, 0, 16'h0000, 16'h0020, 0, 16'hF000, 16'h0012, 0, 1);
        tbl[23] = mk(0, 0, 16'h0000, 1, 16'h8888, 16'h0022, 1, 16'h8888, 16'h0022, 0, 1);
        // PC wrap at the top of the address space
        tbl[24] = mk(0, 1, 16'hFFFE, 1, 16'h0000, 16'hFFFE, 0, 16'h0000, 16'h0022, 0, 1);
        tbl[25] = mk(0, 0, 16'h0000, 1, 16'h9999, 16'h0000, 1, 16'h9999, 16'h0000, 0, 1);
        tbl[26] = mk(0, 0, 16'h0000, 1, 16'hAAAA, 16'h0002, 1, 16'hAAAA, 16'h0002, 0, 1);

        rst = 1'b1;
        stall = 1'b0; flush = 1'b0; br_target = 16'h0; imem_rdy = 1'b1; imem_data = 16'h0;
        @(posedge clk);
        #1;
        chk("reset imem_req", {15'd0, imem_req}, 16'd0);
        step(0, 0, 16'h0, 1, 16'hDEAD);
        chk_all("reset", 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        rst = 1'b0;
        #1;
        chk("post-reset imem_req", {15'd0, imem_req}, 16'd1);

        for (int i = 0; i < NV; i++) begin
            step(tbl[i].stall, tbl[i].flush, tbl[i].tgt, tbl[i].rdy, tbl[i].data);
            chk_all($sformatf("v%0d", i), tbl[i].e_pc, tbl[i].e_valid, tbl[i].e_instr,
                    tbl[i].e_pp2, tbl[i].e_halted, tbl[i].e_req);
        end

        // Reset while draining abandons the redirect and restarts at RESET_PC.
        step(0, 1, 16'h0100, 0, 16'h0000);
        chk_all("drain-entry", 16'h0002, 0, 16'h0000, 16'h0002, 0, 1);
        rst = 1'b1;
        stall = 1'b0; flush = 1'b0; imem_rdy = 1'b0;
        #1;
        chk("rst-in-drain imem_req", {15'd0, imem_req}, 16'd0);
        @(posedge clk);
        #1;
        chk_all("rst-in-drain", 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
        rst = 1'b0;
        step(0, 0, 16'h0000, 1, 16'hBBBB);
        chk_all("after-rst", 16'h0002, 1, 16'hBBBB, 16'h0002, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
